// File: rtl/cpu_dtack_gen_pkg.sv
// Shared constants and types for the 68000 DTACK generator slice.
package system_consts;

  localparam int unsigned MEM_SEL_W = 5;
  localparam int unsigned IO_SEL_W  = 7;
  localparam int unsigned SS_SEL_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    WAIT_FIX,
    UNMAPPED,
    ACK,
    DRAIN
  } dtack_state_t;

  // A zero tick count still needs a one-bit counter to hold its value.
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks == 0) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/cpu_dtack_gen_if.sv
// CPU bus / decoder / arbiter signals seen by the DTACK generator.
interface cpu_dtack_gen_if;
  import system_consts::*;

  logic                 cpu_as_n;
  logic [1:0]           cpu_ds_n;
  logic [MEM_SEL_W-1:0] mem_sel_n;
  logic [IO_SEL_W-1:0]  io_sel_n;
  logic [SS_SEL_W-1:0]  ss_sel_n;
  logic                 mem_req;
  logic                 mem_ack;
  logic                 cpu_dtack_n;
  logic                 busy;
  logic                 bus_timeout;

  modport master (
    output cpu_as_n, cpu_ds_n, mem_sel_n, io_sel_n, ss_sel_n, mem_ack,
    input  mem_req, cpu_dtack_n, busy, bus_timeout
  );

  modport slave (
    input  cpu_as_n, cpu_ds_n, mem_sel_n, io_sel_n, ss_sel_n, mem_ack,
    output mem_req, cpu_dtack_n, busy, bus_timeout
  );

endinterface

// File: rtl/cpu_dtack_gen_ce_wait_counter.sv
// Loadable down-counter advancing on ce; holds at zero instead of wrapping.
module ce_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (ce && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
  // High in the cycle whose ce edge brings the count to zero.
  assign last = ce && (count == WIDTH'(1));

endmodule

// File: rtl/cpu_dtack_gen.sv
// 68000 bus-cycle terminator: memory handshake, fixed IO wait states, unmapped watchdog.
// Watchdog built only when CPU_DTACK_TIMEOUT_EN is defined.
module cpu_dtack_gen
  import system_consts::*;
#(
  parameter int unsigned IO_WAIT       = 2,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input logic             clk,
  input logic             reset,
  input logic             ce,
  cpu_dtack_gen_if.slave  bus
);

  localparam int unsigned FIX_W = cnt_width(IO_WAIT);

  dtack_state_t state;
  logic dtack_n_q, mem_req_q, busy_q;
  logic start, mem_hit, io_hit, ss_hit;
  logic fix_zero, fix_last, fix_done;

  assign start   = (state == IDLE) && !bus.cpu_as_n && !(&bus.cpu_ds_n);
  assign mem_hit = !(&bus.mem_sel_n);
  assign io_hit  = !(&bus.io_sel_n);
  assign ss_hit  = !(&bus.ss_sel_n);

  ce_wait_counter #(.WIDTH(FIX_W)) u_fix_cnt (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .load     (start),
    .load_val (FIX_W'(IO_WAIT)),
    .zero     (fix_zero),
    .last     (fix_last)
  );
  assign fix_done = fix_zero || fix_last;

`ifdef CPU_DTACK_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_TICKS);
  logic to_zero, to_last, to_done, timeout_q;

  ce_wait_counter #(.WIDTH(TO_W)) u_to_cnt (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .load     (start),
    .load_val (TO_W'(TIMEOUT_TICKS)),
    .zero     (to_zero),
    .last     (to_last)
  );
  assign to_done         = to_zero || to_last;
  assign bus.bus_timeout = timeout_q;
`else
  assign bus.bus_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dtack_n_q <= 1'b1;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CPU_DTACK_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (mem_hit) begin
              state     <= WAIT_MEM;
              mem_req_q <= 1'b1;
            end else if (ss_hit || (io_hit && IO_WAIT == 0)) begin
              state     <= ACK;
              dtack_n_q <= 1'b0;
            end else if (io_hit) begin
              state <= WAIT_FIX;
            end else begin
              state <= UNMAPPED;
            end
          end
        end
        WAIT_MEM: begin
          // An abort coinciding with the ack closes the arbiter cycle without DTACK.
          if (bus.cpu_as_n) begin
            if (bus.mem_ack) begin
              state     <= IDLE;
              mem_req_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.mem_ack) begin
            state     <= ACK;
            mem_req_q <= 1'b0;
            dtack_n_q <= 1'b0;
          end
        end
        WAIT_FIX: begin
          if (bus.cpu_as_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (fix_done) begin
            state     <= ACK;
            dtack_n_q <= 1'b0;
          end
        end
        UNMAPPED: begin
          if (bus.cpu_as_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
`ifdef CPU_DTACK_TIMEOUT_EN
          else if (to_done) begin
            state     <= ACK;
            dtack_n_q <= 1'b0;
            timeout_q <= 1'b1;
          end
`endif
        end
        ACK: begin
          if (bus.cpu_as_n) begin
            state     <= IDLE;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          dtack_n_q <= 1'b1;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_dtack_n = dtack_n_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cpu_dtack_gen.sv
// Directed bench for cpu_dtack_gen; watchdog expectations follow CPU_DTACK_TIMEOUT_EN.
module tb_cpu_dtack_gen;
  import system_consts::*;

  localparam int unsigned IO_WAIT       = 2;
  localparam int unsigned TIMEOUT_TICKS = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ce    = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  cpu_dtack_gen_if bus ();

  cpu_dtack_gen #(.IO_WAIT(IO_WAIT), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cpu_as_n  = 1'b1;
    bus.cpu_ds_n  = 2'b11;
    bus.mem_sel_n = '1;
    bus.io_sel_n  = '1;
    bus.ss_sel_n  = '1;
    bus.mem_ack   = 1'b0;
    ce            = 1'b0;
  endtask

  task automatic drive_start(input logic [4:0] m, input logic [6:0] io, input logic [2:0] ss);
    bus.mem_sel_n = m;
    bus.io_sel_n  = io;
    bus.ss_sel_n  = ss;
    bus.cpu_as_n  = 1'b0;
    bus.cpu_ds_n  = 2'b01;
  endtask

  task automatic test_reset();
    bus_idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    compared++; if (bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL rst_dtack got=%b exp=1", bus.cpu_dtack_n); end
    compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    compared++; if (bus.bus_timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout got=%b exp=0", bus.bus_timeout); end
  endtask

  task automatic test_rom_read();
    logic bad;
    drive_start(5'b11110, '1, '1);
    tick();
    compared++; if (bus.mem_req !== 1'b1) begin mismatched++; $display("FAIL rom_req_rise got=%b exp=1", bus.mem_req); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL rom_busy got=%b exp=1", bus.busy); end
    bus.mem_sel_n = '1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_dtack_n !== 1'b1 || bus.mem_req !== 1'b1) bad = 1'b1;
    end
    compared++; if (bad !== 1'b0) begin mismatched++; $display("FAIL rom_wait got=%b exp=0", bad); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL rom_dtack got=%b exp=0", bus.cpu_dtack_n); end
    compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("FAIL rom_req_drop got=%b exp=0", bus.mem_req); end
    tick(); tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL rom_dtack_hold got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle();
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL rom_release_dtack got=%b exp=1", bus.cpu_dtack_n); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rom_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_io_wait();
    logic early;
    drive_start('1, 7'b1111101, '1);
    ce = 1'b1;
    tick();
    compared++; if (bus.busy !== 1'b1 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL io_start got=%b%b exp=11", bus.busy, bus.cpu_dtack_n); end
    early = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      ce = (i % 4 == 0);
      tick();
      if (bus.cpu_dtack_n !== 1'b1) early = 1'b1;
    end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL io_early got=%b exp=0", early); end
    ce = 1'b1;
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL io_dtack got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle();
    tick();
    compared++; if (bus.busy !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL io_release got=%b%b exp=01", bus.busy, bus.cpu_dtack_n); end
  endtask

  task automatic test_ss_and_priority();
    drive_start('1, '1, 3'b110);
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL ss_dtack got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
    drive_start('1, 7'b1111110, 3'b011);
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL prio_ss_over_io got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
    drive_start(5'b01111, '1, 3'b101);
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b1 || bus.mem_req !== 1'b1) begin mismatched++; $display("FAIL prio_mem_over_ss got=%b%b exp=11", bus.cpu_dtack_n, bus.mem_req); end
    bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL prio_mem_dtack got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
  endtask

  task automatic test_abort_mem();
    drive_start(5'b11101, '1, '1);
    tick(); tick();
    bus.cpu_as_n = 1'b1; bus.cpu_ds_n = 2'b11;
    tick();
    compared++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin mismatched++; $display("FAIL drain_hold got=%b%b exp=11", bus.busy, bus.mem_req); end
    drive_start('1, '1, 3'b110);
    tick(); tick();
    compared++; if (bus.cpu_dtack_n !== 1'b1 || bus.mem_req !== 1'b1) begin mismatched++; $display("FAIL drain_block got=%b%b exp=11", bus.cpu_dtack_n, bus.mem_req); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    compared++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL drain_exit got=%b%b%b exp=001", bus.busy, bus.mem_req, bus.cpu_dtack_n); end
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL drain_next_start got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
  endtask

  task automatic test_simultaneous();
    drive_start(5'b11011, '1, '1);
    tick(); tick();
    bus.cpu_as_n = 1'b1; bus.cpu_ds_n = 2'b11; bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    compared++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL simul got=%b%b%b exp=001", bus.busy, bus.mem_req, bus.cpu_dtack_n); end
  endtask

  task automatic test_ignored_ack_and_fix_abort();
    bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    compared++; if (bus.busy !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL idle_ack got=%b%b exp=01", bus.busy, bus.cpu_dtack_n); end
    drive_start('1, 7'b0111111, '1);
    tick();
    bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
    compared++; if (bus.cpu_dtack_n !== 1'b1 || bus.busy !== 1'b1) begin mismatched++; $display("FAIL fix_ack got=%b%b exp=11", bus.cpu_dtack_n, bus.busy); end
    bus.cpu_as_n = 1'b1; bus.cpu_ds_n = 2'b11;
    tick();
    compared++; if (bus.busy !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL fix_abort got=%b%b exp=01", bus.busy, bus.cpu_dtack_n); end
    bus_idle(); tick();
  endtask

  task automatic test_unmapped();
    logic low_seen;
    drive_start('1, '1, '1);
    tick();
    low_seen = 1'b0;
`ifdef CPU_DTACK_TIMEOUT_EN
    for (int i = 1; i < int'(TIMEOUT_TICKS); i++) begin
      ce = 1'b1; tick();
      if (bus.cpu_dtack_n !== 1'b1) low_seen = 1'b1;
    end
    compared++; if (low_seen !== 1'b0) begin mismatched++; $display("FAIL wd_early got=%b exp=0", low_seen); end
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL wd_dtack got=%b exp=0", bus.cpu_dtack_n); end
    compared++; if (bus.bus_timeout !== 1'b1) begin mismatched++; $display("FAIL wd_flag got=%b exp=1", bus.bus_timeout); end
    bus_idle(); tick();
    compared++; if (bus.bus_timeout !== 1'b1 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL wd_sticky got=%b%b exp=10", bus.bus_timeout, bus.busy); end
`else
    for (int i = 0; i < 1000; i++) begin
      ce = 1'b1; tick();
      if (bus.cpu_dtack_n !== 1'b1) low_seen = 1'b1;
    end
    compared++; if (low_seen !== 1'b0) begin mismatched++; $display("FAIL unm_dtack got=%b exp=0", low_seen); end
    compared++; if (bus.busy !== 1'b1 || bus.bus_timeout !== 1'b0) begin mismatched++; $display("FAIL unm_hang got=%b%b exp=10", bus.busy, bus.bus_timeout); end
    bus_idle(); tick();
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL unm_abort got=%b exp=0", bus.busy); end
`endif
  endtask

  task automatic test_reset_mid();
    drive_start(5'b11110, '1, '1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++; if (bus.mem_req !== 1'b0 || bus.cpu_dtack_n !== 1'b1 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid got=%b%b%b exp=010", bus.mem_req, bus.cpu_dtack_n, bus.busy); end
    bus_idle(); tick();
  endtask

  task automatic test_back_to_back();
    drive_start('1, '1, 3'b101);
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL b2b_ss got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
    drive_start('1, 7'b1110111, '1);
    tick();
    ce = 1'b1;
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b1) begin mismatched++; $display("FAIL b2b_io_first got=%b exp=1", bus.cpu_dtack_n); end
    tick();
    compared++; if (bus.cpu_dtack_n !== 1'b0) begin mismatched++; $display("FAIL b2b_io_second got=%b exp=0", bus.cpu_dtack_n); end
    bus_idle(); tick();
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_rom_read();
    test_io_wait();
    test_ss_and_priority();
    test_abort_mem();
    test_simultaneous();
    test_ignored_ack_and_fix_abort();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_dtack_gen.md
# cpu_dtack_gen

Bus-cycle terminator for the main 68000. Sits directly downstream of the address decoder. Consumes its active-low chip selects and generates `cpu_dtack_n`:
- Memory-backed regions wait on a request/acknowledge handshake with the memory arbiter.
- Register-style regions get a fixed number of CPU-clock wait states.
- Unmapped accesses are optionally terminated by a watchdog.

## Interface
Parameters:
- `IO_WAIT`, 2 — wait states (in `ce` ticks) for fixed-latency regions.
- `TIMEOUT_TICKS`, 64 — `ce` ticks before an unmapped access is force-acknowledged (watchdog build only).

Ports:
- `clk`  in  1  system clock; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  68000 clock-enable pulse; all wait counting advances only when `ce`=1.
- `cpu_as_n`  in  1  CPU address strobe.
- `cpu_ds_n`  in  2  CPU data strobes (UDS, LDS).
- `mem_sel_n`  in  5  {PIVOTn, OBJECTn, SCREENn, WORKn, ROMn} from the decoder.
- `io_sel_n`  in  7  {CCHIPn, EXTENSIONn, PRIORITYn, SOUNDn, IO1n, IO0n, COLORn}.
- `ss_sel_n`  in  3  {SS_VECn, SS_RESETn, SS_SAVEn}; treated as fixed-latency with 0 wait states.
- `mem_req`  out  1  level request to the memory arbiter.
- `mem_ack`  in  1  one-cycle completion pulse from the arbiter.
- `cpu_dtack_n`  out  1  to CPU.
- `busy`  out  1  high whenever state ≠ IDLE.
- `bus_timeout`  out  1  sticky flag, set by a watchdog termination; cleared only by `reset`.

## Operation
- States are IDLE, WAIT_MEM, WAIT_FIX, UNMAPPED, ACK, DRAIN.
- **Start condition:** in IDLE with `cpu_as_n`=0 and `~&cpu_ds_n`. Selects are sampled in the same cycle and the first matching rule applies:
  - Any `mem_sel_n` bit low → WAIT_MEM. `mem_req` goes 1 on the next cycle.
  - Any `ss_sel_n` bit low → ACK directly.
  - Any `io_sel_n` bit low → WAIT_FIX. The wait counter loads `IO_WAIT`.
  - No select low → UNMAPPED. The timeout counter loads `TIMEOUT_TICKS`.
- **WAIT_MEM:** `mem_req` is held at 1. On `mem_ack`=1, drop `mem_req` and go to ACK.
- **WAIT_FIX:** the counter decrements on each `ce`. At count 0 go to ACK. With `IO_WAIT`=0 this behaves identically to the ss path.
- **ACK:** `cpu_dtack_n`=0 and is held until `cpu_as_n`=1, then return to IDLE with `cpu_dtack_n`=1 on the same edge.
- **Abort:** `cpu_as_n` rising in WAIT_FIX or UNMAPPED returns to IDLE. In WAIT_MEM it goes to DRAIN instead.
  - DRAIN keeps `mem_req`=1 until `mem_ack`, then goes to IDLE. It never asserts DTACK. The arbiter transaction is always completed.
- **Ignored inputs:** `mem_ack` outside WAIT_MEM/DRAIN is ignored. A new cycle (AS low again) while in DRAIN is not started until DRAIN exits.
- **Select changes:** changes to the select inputs after the start cycle are ignored.
- **Counter widths:** the wait counter is `$clog2(IO_WAIT+1)` bits and the timeout counter is `$clog2(TIMEOUT_TICKS+1)` bits. Counters never wrap; they hold at 0.

## Timing
- **Reset values:** state=IDLE, `cpu_dtack_n`=1, `mem_req`=0, `busy`=0, `bus_timeout`=0, counters=0. Reset mid-cycle returns to IDLE immediately, even with `mem_req` outstanding; the arbiter is reset by the same `reset`.
- **Outputs:** all outputs are registered.
- **SS path:** DTACK asserts 1 `clk` after the start cycle.
- **Memory path:** `mem_req` rises 1 `clk` after start. DTACK asserts 1 `clk` after the `mem_ack` cycle.
- **IO path:** DTACK asserts on the `clk` following the `IO_WAIT`-th `ce` after start. A `ce` in the start cycle itself does not count.
- **Simultaneous events in WAIT_MEM:** `mem_ack` and `cpu_as_n` rising in the same cycle → IDLE. DTACK is not asserted and `mem_req` drops.

## Configuration
- `CPU_DTACK_TIMEOUT_EN` **defined:** UNMAPPED decrements on `ce`. At 0 it goes to ACK and sets `bus_timeout`.
- `CPU_DTACK_TIMEOUT_EN` **undefined:** UNMAPPED waits for abort only, so the CPU hangs, which matches hardware. `bus_timeout` is tied to 0 and the timeout counter is not built.

## Structure
- `dtack_state_t` enum goes in `system_consts`.
- The shared package also holds the constants for the mem/io/ss select vector widths (5/7/3), used by the top-level wiring.
- One sub-module is natural: `ce_wait_counter`, a load/decrement-on-`ce`/zero-flag counter with a width parameter. It is instantiated once for WAIT_FIX and once for the watchdog.

## Test plan
- **ROM read:** ROMn=0, AS/UDS low → `mem_req`=1 next clk. Arbiter acks 5 clk later → `cpu_dtack_n`=0 next clk. Release AS → `cpu_dtack_n`=1 and `mem_req`=0.
- **IO wait states:** IO0n=0, `IO_WAIT`=2, `ce` every 4 clk → DTACK asserts on the clk after the 2nd `ce`.
- **Abort during memory access:** WORKn access, AS deasserted before `mem_ack` → state DRAIN with `mem_req` held. `mem_ack` → IDLE. DTACK never falls.
- **Unmapped access, watchdog built:** with `CPU_DTACK_TIMEOUT_EN`, `TIMEOUT_TICKS`=64 → DTACK after 64 `ce` and `bus_timeout`=1.
- **Unmapped access, watchdog not built:** without the macro, DTACK stays 1 for 1000 `ce` and `bus_timeout`=0.
- **Reset mid-cycle:** reset asserted in WAIT_MEM → next clk `mem_req`=0, `cpu_dtack_n`=1, `busy`=0.
